// File: rtl/dds_pkg.sv
// Shared widths, waveform encoding and controller state type for the DDS wave reader.
package dds_pkg;

    localparam int ACC_W_DEF   = 32;
    localparam int PHASE_W_DEF = 10;
    localparam int DATA_W_DEF  = 8;
    localparam int AMP_W       = 9;

    localparam logic [AMP_W-1:0] AMP_UNITY = 9'd256;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_SAW    = 2'd2,
        WAVE_TRI    = 2'd3
    } dds_wave_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } dds_state_t;

    // Amplitudes above unity are treated as unity.
    function automatic logic [AMP_W-1:0] amp_clamp(input logic [AMP_W-1:0] a);
        return (a > AMP_UNITY) ? AMP_UNITY : a;
    endfunction

endpackage

// File: rtl/dds_amp_scale.sv
// One-stage registered amplitude scaler for offset-binary samples, referenced to midscale
// and saturated to the full unsigned sample range.
module dds_amp_scale
    import dds_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMP_W-1:0]  i_amp,
    output logic [DATA_W-1:0] o_sample,
    output logic              o_valid
);

    localparam int PROD_W = DATA_W + AMP_W + 2;

    localparam logic [DATA_W:0]   MID_X  = {2'b01, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] TOP    = {DATA_W{1'b1}};

    logic signed [DATA_W:0]   w_diff;
    logic        [AMP_W-1:0]  w_amp_eff;
    logic signed [PROD_W-1:0] w_diff_x;
    logic signed [PROD_W-1:0] w_amp_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_shift;
    logic signed [PROD_W-1:0] w_res;
    logic signed [PROD_W-1:0] w_mid_x;
    logic signed [PROD_W-1:0] w_top_x;
    logic        [DATA_W-1:0] w_sat;

    logic [DATA_W-1:0] r_sample;
    logic              r_valid;

    assign w_diff    = $signed({1'b0, i_data}) - $signed(MID_X);
    assign w_amp_eff = amp_clamp(i_amp);

    assign w_diff_x  = {{(PROD_W-DATA_W-1){w_diff[DATA_W]}}, w_diff};
    assign w_amp_x   = $signed({{(PROD_W-AMP_W){1'b0}}, w_amp_eff});
    assign w_prod    = w_diff_x * w_amp_x;
    assign w_shift   = w_prod >>> 8;

    assign w_mid_x   = $signed({{(PROD_W-DATA_W){1'b0}}, MID});
    assign w_top_x   = $signed({{(PROD_W-DATA_W){1'b0}}, TOP});
    assign w_res     = w_shift + w_mid_x;

    always_comb begin
        w_sat = w_res[DATA_W-1:0];
        if (w_res < 0) begin
            w_sat = '0;
        end else if (w_res > w_top_x) begin
            w_sat = TOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= MID;
            r_valid  <= 1'b0;
        end else begin
            if (i_en) begin
                r_sample <= w_sat;
            end
            r_valid <= i_en;
        end
    end

    assign o_sample = r_sample;
    assign o_valid  = r_valid;

endmodule

// File: rtl/dds_wave_reader.sv
// Phase-accumulator DDS front end: steps a waveform ROM address, swaps configuration on
// accumulator carry-out and scales the returned samples by the issuing amplitude.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | en low, accumulator and address frozen
//   ST_RUN  | running, pending slot empty
//   ST_PEND | running, pending config waiting for carry-out
module dds_wave_reader
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ACC_W-1:0]     cfg_ftw,
    input  logic [PHASE_W-1:0]   cfg_pow,
    input  logic [1:0]           cfg_wave,
    input  logic [AMP_W-1:0]     cfg_amp,
    output logic [PHASE_W+1:0]   rom_ad,
    output logic                 rom_ce,
    output logic                 rom_oce,
    output logic                 rom_reset,
    input  logic [DATA_W-1:0]    rom_dout,
    output logic [DATA_W-1:0]    sample,
    output logic                 sample_valid,
    output logic                 wrap
);

    dds_state_t r_state;
    dds_state_t w_state_nxt;

    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_ftw;
    logic [PHASE_W-1:0] r_pow;
    logic [1:0]         r_wave;
    logic [AMP_W-1:0]   r_amp;

    logic               r_pend;
    logic [ACC_W-1:0]   r_p_ftw;
    logic [PHASE_W-1:0] r_p_pow;
    logic [1:0]         r_p_wave;
    logic [AMP_W-1:0]   r_p_amp;

    logic [PHASE_W+1:0] r_rom_ad;
    logic               r_rom_ce;
    logic               r_ce_d1;
    logic               r_wrap;
    logic [AMP_W-1:0]   r_amp_ad;
    logic [AMP_W-1:0]   r_amp_dat;

    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic [PHASE_W-1:0] w_phase;
    logic               w_take;
    logic               w_promote;
    logic               w_pend_nxt;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_ftw};
    assign w_carry = w_sum[ACC_W];
    assign w_phase = r_acc[ACC_W-1 -: PHASE_W] + r_pow;
    assign w_take  = cfg_valid & ~r_pend;

    // A held config swaps in at the carry-out while running, or at once while stopped.
    // A config accepted on a carry cycle is not yet in r_pend, so it waits a full period.
    always_comb begin
        w_promote   = r_pend & (~en | w_carry);
        w_pend_nxt  = (r_pend & ~w_promote) | w_take;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = w_pend_nxt ? ST_PEND : ST_RUN;
                end
            end
            ST_RUN, ST_PEND: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = w_pend_nxt ? ST_PEND : ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ftw    <= '0;
            r_pow    <= '0;
            r_wave   <= '0;
            r_amp    <= AMP_UNITY;
            r_pend   <= 1'b0;
            r_p_ftw  <= '0;
            r_p_pow  <= '0;
            r_p_wave <= '0;
            r_p_amp  <= '0;
        end else if (w_promote) begin
            r_ftw  <= r_p_ftw;
            r_pow  <= r_p_pow;
            r_wave <= r_p_wave;
            r_amp  <= r_p_amp;
            r_pend <= 1'b0;
        end else if (w_take) begin
            r_p_ftw  <= cfg_ftw;
            r_p_pow  <= cfg_pow;
            r_p_wave <= cfg_wave;
            r_p_amp  <= cfg_amp;
            r_pend   <= 1'b1;
        end
    end

    // The amplitude travels with its address so a mid-stream swap lines up with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_rom_ad  <= '0;
            r_rom_ce  <= 1'b0;
            r_ce_d1   <= 1'b0;
            r_wrap    <= 1'b0;
            r_amp_ad  <= AMP_UNITY;
            r_amp_dat <= AMP_UNITY;
        end else begin
            if (en) begin
                r_acc    <= w_sum[ACC_W-1:0];
                r_rom_ad <= {r_wave, w_phase};
                r_amp_ad <= r_amp;
            end
            r_rom_ce  <= en;
            r_ce_d1   <= r_rom_ce;
            r_wrap    <= en & w_carry;
            r_amp_dat <= r_amp_ad;
        end
    end

    dds_amp_scale #(
        .DATA_W (DATA_W)
    ) u_scale (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (r_ce_d1),
        .i_data   (rom_dout),
        .i_amp    (r_amp_dat),
        .o_sample (sample),
        .o_valid  (sample_valid)
    );

    assign cfg_ready = ~r_pend;
    assign rom_ad    = r_rom_ad;
    assign rom_ce    = r_rom_ce;
    assign rom_oce   = 1'b1;
    assign rom_reset = ~rst_n;
    assign wrap      = r_wrap;

endmodule
